dlfloat_byte_rx: RTL and testbench

//  Receive end of the MAC result byte stream: rebuilds DLfloat16 words from 8-bit bytes sent MSB first, then LSB.

---
 rtl/dlfloat_byte_rx.sv | 138 +++++++++++++
 tb/tb_dlfloat_byte_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_byte_rx.sv
// DLfloat16 byte-stream receiver: pairs MSB/LSB bytes into words and queues them in a small FIFO.
// Optional head classification (is_zero / is_nan) is built only when DLFLOAT_RX_CLASS_EN is defined.
module dlfloat_byte_rx #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  input  logic                       in_sync,
  output logic [15:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       frame_err,
  output logic                       is_zero,
  output logic                       is_nan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    EXP_MSB = 1'b0,
    EXP_LSB = 1'b1
  } state_t;

  state_t          r_state;
  logic [7:0]      r_msb;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_frame_err;
  logic [15:0]     r_mem [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_word_done;
  logic            w_pop;
  logic            w_push;
  logic [15:0]     w_word;
  logic [AW-1:0]   w_wr_idx;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_word_done = (r_state == EXP_LSB) && in_valid && !in_sync;
  assign w_pop       = !w_empty && out_ready && !clr;
  // When full, a same-cycle pop frees the slot the new word is written into.
  assign w_push      = w_word_done && (!w_full || w_pop) && !clr;
  assign w_word      = {r_msb, in_byte};
  assign w_wr_idx    = r_wr_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EXP_MSB;
      r_msb       <= 8'h00;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (clr) begin
      r_state     <= EXP_MSB;
      r_msb       <= 8'h00;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (in_valid) begin
        case (r_state)
          EXP_MSB: begin
            r_msb   <= in_byte;
            r_state <= EXP_LSB;
          end
          EXP_LSB: begin
            if (in_sync) begin
              r_msb       <= in_byte;
              r_frame_err <= 1'b1;
            end else begin
              r_state <= EXP_MSB;
            end
          end
          default: r_state <= EXP_MSB;
        endcase
      end

      if (w_word_done && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is reset so the head reads as a defined value before the first write.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= 16'h0000;
        end else if (w_push && (w_wr_idx == AW'(gi))) begin
          r_mem[gi] <= w_word;
        end
      end
    end
  endgenerate

  assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid = !w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

`ifdef DLFLOAT_RX_CLASS_EN
  assign is_zero = out_valid && (out_data == 16'h0000);
  assign is_nan  = out_valid && (out_data == 16'hFFFF);
`else
  assign is_zero = 1'b0;
  assign is_nan  = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_byte_rx.sv
// Scoreboard bench for dlfloat_byte_rx: stimulus queues expected words, a monitor checks every pop.
module tb_dlfloat_byte_rx;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          frame_err;
  logic          is_zero;
  logic          is_nan;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

`ifdef DLFLOAT_RX_CLASS_EN
  localparam logic CLASS_ON = 1'b1;
`else
  localparam logic CLASS_ON = 1'b0;
`endif

  dlfloat_byte_rx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_byte(in_byte), .in_valid(in_valid), .in_sync(in_sync),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .frame_err(frame_err),
    .is_zero(is_zero), .is_nan(is_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: a pop happens at the next rising edge whenever valid & ready are high here.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %h, required no word", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %h, required %h", out_data, e);
        end else begin
          $display("pop ok: %h", out_data);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic s);
    in_byte  = b;
    in_sync  = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check({name, "_drained_valid"}, int'(out_valid), 0);
    check({name, "_scoreboard_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_count", int'(count), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single word, one-cycle latency
    exp_q.push_back(16'h3E00);
    send(8'h3E, 1'b1);
    check("t1_valid_after_msb", int'(out_valid), 0);
    send(8'h00, 1'b0);
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_out_data", int'(out_data), 16'h3E00);
    check("t1_count", int'(count), 1);
    drain("t1");

    // T2: five words into a 4-deep FIFO, fifth dropped
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] v;
      v = 8'(i * 8'h01);
      if (i <= DEPTH) exp_q.push_back({v, v});
      send(v, 1'b1);
      send(v, 1'b0);
    end
    check("t2_count_full", int'(count), 4);
    check("t2_overflow", int'(overflow), 1);
    check("t2_head", int'(out_data), 16'h0101);
    drain("t2");
    check("t2_count_empty", int'(count), 0);
    check("t2_overflow_sticky", int'(overflow), 1);
    do_clr();
    check("t2_clr_overflow", int'(overflow), 0);

    // T3: framing slip
    exp_q.push_back(16'h3456);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    check("t3_no_word_yet", int'(out_valid), 0);
    send(8'h56, 1'b0);
    check("t3_frame_err", int'(frame_err), 1);
    check("t3_count", int'(count), 1);
    check("t3_out_data", int'(out_data), 16'h3456);
    drain("t3");
    do_clr();
    check("t3_clr_frame_err", int'(frame_err), 0);

    // T4: push into full FIFO with a simultaneous pop
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    exp_q.push_back(16'hA0A5);
    send(8'h11, 1'b0); send(8'h11, 1'b0);
    send(8'h22, 1'b0); send(8'h22, 1'b0);
    send(8'h33, 1'b0); send(8'h33, 1'b0);
    send(8'h44, 1'b0); send(8'h44, 1'b0);
    check("t4_full_count", int'(count), 4);
    send(8'hA0, 1'b0);
    out_ready = 1'b1;
    send(8'hA5, 1'b0);
    out_ready = 1'b0;
    check("t4_count", int'(count), 4);
    check("t4_overflow", int'(overflow), 0);
    check("t4_head", int'(out_data), 16'h2222);
    drain("t4");

    // T5: reset discards a half frame
    send(8'h77, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(16'hABCD);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    check("t5r_count", int'(count), 1);
    check("t5r_out_data", int'(out_data), 16'hABCD);
    check("t5r_flags", int'({overflow, frame_err}), 0);
    drain("t5r");

    // T5 with clr instead of reset
    send(8'h77, 1'b0);
    do_clr();
    exp_q.push_back(16'hABCD);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    check("t5c_count", int'(count), 1);
    check("t5c_out_data", int'(out_data), 16'hABCD);
    check("t5c_flags", int'({overflow, frame_err}), 0);
    drain("t5c");

    // T6: head classification
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    check("t6_is_nan", int'(is_nan), int'(CLASS_ON));
    check("t6_is_zero_nan_head", int'(is_zero), 0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("t6_is_zero_behind", int'(is_zero), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t6_is_zero", int'(is_zero), int'(CLASS_ON));
    check("t6_is_nan_zero_head", int'(is_nan), 0);
    drain("t6");
    check("t6_is_zero_empty", int'(is_zero), 0);
    check("final_count", int'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
